// File: rtl/joy_pkg.sv
// Shared types and default sizing for the DB9 joystick chain reader.
package joy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLK_LO,
        ST_CLK_HI,
        ST_DONE,
        ST_GAP
    } joy_state_t;

    localparam int JOY_NBITS_DEF   = 24;
    localparam int JOY_CLK_DIV_DEF = 25;

endpackage

// File: rtl/joy_tick_gen.sv
// Half-period tick: one-cycle pulse every CLK_DIV cycles, zero latency from the counter; no backpressure.
// clr restarts the period so the following state gets a full CLK_DIV cycles.
module joy_tick_gen
    import joy_pkg::*;
#(
    parameter int CLK_DIV = JOY_CLK_DIV_DEF
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic clr,
    output logic tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/joy_db9_reader.sv
// Drives a 74HC165 DB9 chain and decodes two active-high words, updated 1 cycle after the last shift tick; no backpressure.
// Define JOY_FILTER_EN to require two identical consecutive frames before JOY1/JOY2 change.
module joy_db9_reader
    import joy_pkg::*;
#(
    parameter int CLK_DIV   = JOY_CLK_DIV_DEF,
    parameter int NBITS     = JOY_NBITS_DEF,
    parameter int FRAME_GAP = 16
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    input  logic               ENABLE,
    input  logic               JOY_DATA,
    output logic               JOY_CLK,
    output logic               JOY_LOAD_N,
    output logic [NBITS/2-1:0] JOY1,
    output logic [NBITS/2-1:0] JOY2,
    output logic               FRAME_VALID
);
    localparam int HALF = NBITS / 2;
    localparam int IW   = $clog2(NBITS);
    localparam int GW   = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NBITS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(FRAME_GAP - 1);

    joy_state_t       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic [HALF-1:0]  joy1_q, joy1_d, joy2_q, joy2_d;
    logic             fv_q, fv_d;
    logic             joy_clk_q, joy_clk_d;
    logic             load_n_q, load_n_d;
    logic             tick, clr;
    logic [NBITS-1:0] word;
`ifdef JOY_FILTER_EN
    logic [NBITS-1:0] prev_q, prev_d;
`endif

    assign word = ~shreg_q;

    joy_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .clr      (clr),
        .tick     (tick)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        shreg_d = shreg_q;
        joy1_d  = joy1_q;
        joy2_d  = joy2_q;
        fv_d    = 1'b0;
`ifdef JOY_FILTER_EN
        prev_d  = prev_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (tick && ENABLE) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                idx_d = '0;
                if (tick) state_d = ST_CLK_LO;
            end
            ST_CLK_LO: begin
                // Sample a full half-period after the last shift edge to cover 165 propagation delay.
                if (tick) begin
                    shreg_d[IDX_LAST - idx_q] = JOY_DATA;
                    state_d = ST_CLK_HI;
                end
            end
            ST_CLK_HI: begin
                if (tick) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = ST_CLK_LO;
                    end
                end
            end
            ST_DONE: begin
`ifdef JOY_FILTER_EN
                prev_d = word;
                if (word == prev_q) begin
                    joy1_d = word[NBITS-1 -: HALF];
                    joy2_d = word[HALF-1:0];
                end
`else
                joy1_d = word[NBITS-1 -: HALF];
                joy2_d = word[HALF-1:0];
`endif
                fv_d    = 1'b1;
                gap_d   = '0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (tick) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = ENABLE ? ST_LOAD : ST_IDLE;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // DONE is a single extra cycle; parking the divider there keeps GAP a whole number of periods.
        clr       = (state_q == ST_DONE) || (state_d == ST_LOAD && state_q != ST_LOAD);
        joy_clk_d = (state_d == ST_CLK_HI);
        load_n_d  = (state_d != ST_LOAD);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            gap_q     <= '0;
            shreg_q   <= '0;
            joy1_q    <= '0;
            joy2_q    <= '0;
            fv_q      <= 1'b0;
            joy_clk_q <= 1'b0;
            load_n_q  <= 1'b1;
`ifdef JOY_FILTER_EN
            prev_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            shreg_q   <= shreg_d;
            joy1_q    <= joy1_d;
            joy2_q    <= joy2_d;
            fv_q      <= fv_d;
            joy_clk_q <= joy_clk_d;
            load_n_q  <= load_n_d;
`ifdef JOY_FILTER_EN
            prev_q    <= prev_d;
`endif
        end
    end

    assign JOY_CLK     = joy_clk_q;
    assign JOY_LOAD_N  = load_n_q;
    assign JOY1        = joy1_q;
    assign JOY2        = joy2_q;
    assign FRAME_VALID = fv_q;

endmodule

// File: tb/tb_joy_db9_reader.sv
// Directed bench for joy_db9_reader: 165 chain model, decoded-word scoreboard, optional JOY_FILTER_EN model.
module tb_joy_db9_reader;
    localparam int DIV    = 25;
    localparam int NB     = 24;
    localparam int GAPN   = 16;
    localparam int PERIOD = DIV * (1 + 2 * NB + GAPN) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, jd, jclk, jload_n, fv;
    logic [11:0] j1, j2;
    logic rst2, en2, jd2, jclk2, jload2_n, fv2;
    logic [11:0] j1b, j2b;

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] pat = '1, pat2 = '1;
    logic [23:0] sr = '1, sr2 = '1;
    logic jclk_p = 1'b0, jclk2_p = 1'b0;

    joy_db9_reader dut (
        .CLOCK_50(clk), .RESET(rst), .ENABLE(en), .JOY_DATA(jd),
        .JOY_CLK(jclk), .JOY_LOAD_N(jload_n), .JOY1(j1), .JOY2(j2), .FRAME_VALID(fv)
    );

    joy_db9_reader #(.CLK_DIV(2)) dut2 (
        .CLOCK_50(clk), .RESET(rst2), .ENABLE(en2), .JOY_DATA(jd2),
        .JOY_CLK(jclk2), .JOY_LOAD_N(jload2_n), .JOY1(j1b), .JOY2(j2b), .FRAME_VALID(fv2)
    );

    // 74HC165 chain: parallel load while LOAD_N low, shift towards the serial output on JOY_CLK rise.
    assign jd  = sr[23];
    assign jd2 = sr2[23];
    always @(posedge clk) begin
        jclk_p <= jclk;
        if (!jload_n) sr <= pat;
        else if (jclk && !jclk_p) sr <= {sr[22:0], 1'b1};
        jclk2_p <= jclk2;
        if (!jload2_n) sr2 <= pat2;
        else if (jclk2 && !jclk2_p) sr2 <= {sr2[22:0], 1'b1};
    end

    int rise_cnt = 0, last_rise = 0;
    logic mon_p = 1'b0;
    always @(negedge clk) begin
        if (!jload_n) rise_cnt <= 0;
        else if (jclk && !mon_p) rise_cnt <= rise_cnt + 1;
        mon_p <= jclk;
        if (fv) last_rise <= rise_cnt;
    end

    logic [23:0] exp_q[$];
    logic [23:0] out_m = '0, prev_m = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [23:0] p);
        exp_q.push_back(~p);
    endtask

    task automatic pop_check(input string tag);
        logic [23:0] w;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: scoreboard empty at FRAME_VALID", tag);
            return;
        end
        w = exp_q.pop_front();
`ifdef JOY_FILTER_EN
        if (w == prev_m) out_m = w;
        prev_m = w;
`else
        out_m = w;
`endif
        check({tag, "_joy1"}, 32'(j1), 32'(out_m[23:12]));
        check({tag, "_joy2"}, 32'(j2), 32'(out_m[11:0]));
    endtask

    task automatic wait_fv(input string tag, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (fv) return;
        end
        vectors++;
        miscompares++;
        $error("FAIL %s: no FRAME_VALID within %0d cycles", tag, budget);
    endtask

    task automatic wait_rise(input string tag, input int target);
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            #1;
            if (rise_cnt == target) return;
        end
        vectors++;
        miscompares++;
        $error("FAIL %s: JOY_CLK rise %0d never seen", tag, target);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_clk"},    32'(jclk),    0);
        check({tag, "_load_n"}, 32'(jload_n), 1);
        check({tag, "_joy1"},   32'(j1),      0);
        check({tag, "_joy2"},   32'(j2),      0);
        check({tag, "_fv"},     32'(fv),      0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, loads, fvs, gaps;
        logic [23:0] seq [5];
        logic p;

        rst = 1'b1; en = 1'b0; rst2 = 1'b1; en2 = 1'b0;
        pat = 24'hFFF_FFE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");

        // First load strobe CLK_DIV cycles after reset release.
        push(pat);
        en = 1'b1;
        rst = 1'b0;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!jload_n) break;
        end
        check("first_load", n, DIV);

        wait_fv("fv1", 3000, n);
        pop_check("frame_fffffe");

        pat = 24'h7FF_FFF;
        push(pat);
        @(posedge clk);
        @(negedge clk);
        check("fv_width", 32'(fv), 0);
        wait_fv("fv2", PERIOD + 100, n);
        check("frame_period", n + 1, PERIOD);
        #1;
        check("clk_rises", last_rise, NB);
        pop_check("frame_7fffff");

        // ENABLE dropped mid-frame: frame completes, then the block idles.
        pat = 24'h555_AAA;
        push(pat);
        wait_rise("bit10", 10);
        en = 1'b0;
        wait_fv("fv3", 3000, n);
        pop_check("frame_drop_en");
        loads = 0; fvs = 0;
        repeat (2 * PERIOD) begin
            @(negedge clk);
            if (!jload_n) loads++;
            if (fv) fvs++;
        end
        check("idle_loads", loads, 0);
        check("idle_fv", fvs, 0);
        check("idle_hold_joy1", 32'(j1), 32'(out_m[23:12]));
        check("idle_hold_joy2", 32'(j2), 32'(out_m[11:0]));

        // Reset in the middle of an all-pressed frame.
        pat = 24'h000_000;
        en = 1'b1;
        wait_rise("bit12", 12);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("mid_reset");
        exp_q.delete();
        out_m = '0;
        prev_m = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push(pat);
        repeat (100) @(negedge clk);
        check("post_reset_joy1", 32'(j1), 0);
        check("post_reset_joy2", 32'(j2), 0);
        wait_fv("fv4", 3000, n);
        pop_check("frame_000000");

        // Glitch frame between clean frames, then a real change held for two frames.
        seq[0] = 24'hFFF_FFF; seq[1] = 24'hFFE_FFF; seq[2] = 24'hFFF_FFF;
        seq[3] = 24'hFFE_FFF; seq[4] = 24'hFFE_FFF;
        for (int i = 0; i < 5; i++) begin
            pat = seq[i];
            push(pat);
            wait_fv("fv_seq", PERIOD + 100, n);
            pop_check("frame_seq");
`ifdef JOY_FILTER_EN
            if (i == 1) check("filter_glitch_joy1", 32'(j1), 0);
            if (i == 4) check("filter_change_joy1", 32'(j1), 12'h001);
`endif
        end

        // Fastest divider.
        pat2 = 24'h3C5_A96;
        en2 = 1'b1;
        rst2 = 1'b0;
        p = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (jclk2 && !p) break;
            p = jclk2;
        end
        p = jclk2;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (jclk2 && !p) break;
            p = jclk2;
        end
        check("div2_clk_period", n, 4);
        gaps = 0;
        n = 0;
        while (n < 2000 && gaps < 2) begin
            @(negedge clk);
            n++;
            if (fv2) gaps++;
        end
        check("div2_frames", gaps, 2);
        check("div2_joy1", 32'(j1b), 32'(12'hC3A));
        check("div2_joy2", 32'(j2b), 32'(12'h569));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
